// File: rtl/game_pkg.sv
// Shared game encodings and per-level spawn table, used by the game-flow
// controller, the renderer and the top level.
package game_pkg;

  localparam int MAX_LEVELS = 4;

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_OVER  = 3'd1,
    S_WIN   = 3'd2,
    S_INTRO = 3'd3,
    S_DYING = 3'd4
  } game_state_e;

  localparam logic [9:0] SPAWN_X = 10'd20;

  // Spawn Y per level; levels 2 and 3 are reserved for future layouts.
  function automatic logic [9:0] spawn_y(input logic [1:0] lvl);
    logic [9:0] y;
    case (lvl)
      2'd0:    y = 10'd344;
      2'd1:    y = 10'd364;
      2'd2:    y = 10'd324;
      default: y = 10'd304;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/game_flow_controller_phase_timer.sv
// 8-bit loadable down counter with tick enable. expired_o is high while the
// count is zero, so loading T-1 gives a phase of exactly T ticks.
module phase_timer #(
  parameter logic [7:0] RESET_VAL = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       tick_i,
  output logic [7:0] count_o,
  output logic       expired_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Load wins over decrement; the counter parks at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = (count_q == 8'd0);

endmodule

// File: rtl/game_flow_controller.sv
// Game-flow sequencer: owns game state, level, lives, score, freeze and the
// respawn / level-start pulse sequencing between physics and renderer.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int NUM_LEVELS  = 2,
  parameter int START_LIVES = 3,
  parameter int INTRO_TICKS = 90,
  parameter int DEATH_TICKS = 60,
  parameter int WIN_TICKS   = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_tick,
  input  logic        restart,
  input  logic        in_lava,
  input  logic        hit_lava_wall,
  input  logic        hit_enemy,
  input  logic        at_goal_region,
  input  logic        jump_landed_pulse,
  output logic [2:0]  game_state,
  output logic [1:0]  level,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic        freeze,
  output logic        reset_player,
  output logic [9:0]  reset_x,
  output logic [9:0]  reset_y,
  output logic        level_start_pulse,
  output logic        lava_boost_pulse
);

  localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [7:0] INTRO_LD   = 8'(INTRO_TICKS - 1);
  localparam logic [7:0] DEATH_LD   = 8'(DEATH_TICKS - 1);
  localparam logic [7:0] WIN_LD     = 8'(WIN_TICKS - 1);

  game_state_e state_q, state_d;
  logic [1:0]  level_q, level_d;
  logic [1:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [9:0]  reset_y_q, reset_y_d;
  logic        boost_q, boost_d;
  logic        entry_q, entry_d;
  logic        reset_player_q, level_start_q;
  logic        land_pend_q, rst_pend_q, restart_q;
  logic        tmr_load;
  logic [7:0]  tmr_val;
  logic [7:0]  tmr_count;
  logic        tmr_expired;
  logic        hazard;
  logic        intro_go;
  logic        restart_go;

  assign hazard = in_lava | hit_lava_wall | hit_enemy;

  phase_timer #(
    .RESET_VAL (INTRO_LD)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tick_i     (game_tick),
    .count_o    (tmr_count),
    .expired_o  (tmr_expired)
  );

  // Clk-domain latches: a set arriving with the consuming tick survives it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      land_pend_q <= 1'b0;
      rst_pend_q  <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      restart_q   <= restart;
      land_pend_q <= jump_landed_pulse | (land_pend_q & ~game_tick);
      rst_pend_q  <= (restart & ~restart_q) | (rst_pend_q & ~game_tick);
    end
  end

  // Next-state, scoring and lives logic; evaluated only on game ticks.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    lives_d    = lives_q;
    score_d    = score_q;
    reset_y_d  = reset_y_q;
    boost_d    = 1'b0;
    entry_d    = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = INTRO_LD;
    intro_go   = 1'b0;
    restart_go = 1'b0;

    if (game_tick) begin
      case (state_q)
        S_INTRO: begin
          if (tmr_expired) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (hazard) begin
            state_d  = S_DYING;
            lives_d  = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            tmr_load = 1'b1;
            tmr_val  = DEATH_LD;
          end else if (at_goal_region) begin
            state_d  = S_WIN;
            tmr_load = 1'b1;
            tmr_val  = WIN_LD;
          end else if (land_pend_q) begin
            score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
            boost_d = 1'b1;
          end
        end
        S_DYING: begin
          if (tmr_expired) begin
            if (lives_q == 2'd0) begin
              state_d = S_OVER;
            end else begin
              intro_go = 1'b1;
            end
          end
        end
        S_WIN: begin
          if (level_q == LAST_LEVEL) begin
            restart_go = rst_pend_q;
          end else if (tmr_expired) begin
            level_d  = level_q + 2'd1;
            intro_go = 1'b1;
          end
        end
        S_OVER: begin
          restart_go = rst_pend_q;
        end
        default: begin
          state_d = S_INTRO;
        end
      endcase

      if (restart_go) begin
        level_d  = 2'd0;
        lives_d  = LIVES_INIT;
        score_d  = 16'd0;
        intro_go = 1'b1;
      end

      // Every non-reset intro entry republishes the spawn point and arms
      // the delayed respawn / level-start pulses.
      if (intro_go) begin
        state_d   = S_INTRO;
        tmr_load  = 1'b1;
        tmr_val   = INTRO_LD;
        entry_d   = 1'b1;
        reset_y_d = spawn_y(level_d);
      end
    end
  end

  // Game state registers and the one-clk pulse pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_INTRO;
      level_q        <= 2'd0;
      lives_q        <= LIVES_INIT;
      score_q        <= 16'd0;
      reset_y_q      <= spawn_y(2'd0);
      boost_q        <= 1'b0;
      entry_q        <= 1'b0;
      reset_player_q <= 1'b0;
      level_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      lives_q        <= lives_d;
      score_q        <= score_d;
      reset_y_q      <= reset_y_d;
      boost_q        <= boost_d;
      entry_q        <= entry_d;
      reset_player_q <= entry_q;
      level_start_q  <= entry_q;
    end
  end

  assign game_state        = state_q;
  assign level             = level_q;
  assign lives             = lives_q;
  assign score             = score_q;
  assign freeze            = (state_q != S_RUN);
  assign reset_player      = reset_player_q;
  assign reset_x           = SPAWN_X;
  assign reset_y           = reset_y_q;
  assign level_start_pulse = level_start_q;
  assign lava_boost_pulse  = boost_q;

  logic unused_ok;
  assign unused_ok = ^tmr_count;

endmodule
